// File: rtl/logic_writeback_multi_pkg.sv
// Shared types and defaults for the multi-lane writeback stage.
package logic_writeback_multi_pkg;

  localparam int unsigned NUM_PE_DEF          = 4;
  localparam int unsigned WORD_SIZE_DEF       = 16;
  localparam int unsigned ADDR_W_DEF          = 16;
  localparam int unsigned WORDS_PER_FRAME_DEF = 40;

  typedef logic [ADDR_W_DEF-1:0]    addr_t;
  typedef logic [WORD_SIZE_DEF-1:0] data_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } wb_state_t;

  // Counter width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/logic_writeback_multi_if.sv
// PE-array beat input and frame-RAM write port of the writeback stage.
interface logic_writeback_multi_if
  import logic_writeback_multi_pkg::*;
#(
  parameter int unsigned NUM_PE    = NUM_PE_DEF,
  parameter int unsigned WORD_SIZE = WORD_SIZE_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF
);

  logic                 start_in;
  logic                 stall_in;
  logic [NUM_PE-1:0]    next_state_in;
  logic                 wr_en_out;
  logic [ADDR_W-1:0]    addr_w_out;
  logic [WORD_SIZE-1:0] data_w_out;
  logic                 buf_sel_out;
  logic                 busy_out;
  logic                 done_out;

  modport master (
    output start_in, stall_in, next_state_in,
    input  wr_en_out, addr_w_out, data_w_out, buf_sel_out, busy_out, done_out
  );

  modport slave (
    input  start_in, stall_in, next_state_in,
    output wr_en_out, addr_w_out, data_w_out, buf_sel_out, busy_out, done_out
  );

endinterface

// File: rtl/logic_writeback_multi_word_packer.sv
// Packs NUM_PE-bit beats MSB-first into WORD_SIZE-bit words.
module logic_writeback_multi_word_packer
  import logic_writeback_multi_pkg::*;
#(
  parameter int unsigned NUM_PE    = NUM_PE_DEF,
  parameter int unsigned WORD_SIZE = WORD_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 valid,
  input  logic [NUM_PE-1:0]    beat,
  output logic                 last_slice,
  output logic                 word_done,
  output logic [WORD_SIZE-1:0] word
);

  localparam int unsigned BEATS   = WORD_SIZE / NUM_PE;
  localparam int unsigned SLICE_W = clog2_min1(BEATS);
  localparam logic [SLICE_W-1:0] LAST = SLICE_W'(BEATS - 1);

  logic [SLICE_W-1:0]   slice_q, slice_eff;
  logic [WORD_SIZE-1:0] shift_q, shift_eff;

  // clear acts in the same cycle so that a concurrently accepted beat lands as beat 0
  always_comb begin
    slice_eff  = clear ? '0 : slice_q;
    shift_eff  = clear ? '0 : shift_q;
    last_slice = (slice_q == LAST);
    word_done  = valid && (slice_eff == LAST);
    word       = (shift_eff << NUM_PE) | WORD_SIZE'(beat);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slice_q <= '0;
      shift_q <= '0;
    end else if (valid) begin
      slice_q <= word_done ? '0 : slice_eff + SLICE_W'(1);
      shift_q <= word_done ? '0 : word;
    end else if (clear) begin
      slice_q <= '0;
      shift_q <= '0;
    end
  end

endmodule

// File: rtl/logic_writeback_multi.sv
// Writeback stage: packs PE results into words, writes them to a ping-pong frame RAM.
module logic_writeback_multi
  import logic_writeback_multi_pkg::*;
#(
  parameter int unsigned NUM_PE          = NUM_PE_DEF,
  parameter int unsigned WORD_SIZE       = WORD_SIZE_DEF,
  parameter int unsigned ADDR_W          = ADDR_W_DEF,
  parameter int unsigned WORDS_PER_FRAME = WORDS_PER_FRAME_DEF
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  logic_writeback_multi_if.slave  bus
);

  localparam int unsigned IDX_W = clog2_min1(WORDS_PER_FRAME);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS_PER_FRAME - 1);
  localparam logic [ADDR_W-1:0] BASE1    = ADDR_W'(WORDS_PER_FRAME);

  if (WORD_SIZE % NUM_PE != 0) begin : g_bad_cfg
    $error("logic_writeback_multi: WORD_SIZE must be a multiple of NUM_PE");
  end

  wb_state_t            state_q;
  logic [IDX_W-1:0]     word_idx_q, idx_eff;
  logic                 wr_en_q, done_q, busy_q, buf_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [WORD_SIZE-1:0] data_q;

  logic                 accept, final_beat, clear, frame_end, buf_eff;
  logic                 last_slice, word_done;
  logic [WORD_SIZE-1:0] word;

  // A start coinciding with the frame's final beat must not clear: that beat
  // still completes the last word, and the new frame begins with the next beat.
  // buf_eff lets a word completing while done is high already use the next buffer.
  always_comb begin
    accept     = (state_q == ST_RUN || bus.start_in) && !bus.stall_in;
    final_beat = (state_q == ST_RUN) && accept && last_slice && (word_idx_q == LAST_IDX);
    clear      = bus.start_in && !final_beat;
    idx_eff    = clear ? '0 : word_idx_q;
    frame_end  = word_done && (idx_eff == LAST_IDX);
    buf_eff    = done_q ? !buf_q : buf_q;
  end

  logic_writeback_multi_word_packer #(
    .NUM_PE    (NUM_PE),
    .WORD_SIZE (WORD_SIZE)
  ) u_packer (
    .clk        (clk_in),
    .rst        (rst_in),
    .clear      (clear),
    .valid      (accept),
    .beat       (bus.next_state_in),
    .last_slice (last_slice),
    .word_done  (word_done),
    .word       (word)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      word_idx_q <= '0;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      buf_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      wr_en_q <= word_done;
      done_q  <= frame_end;
      buf_q   <= buf_eff;
      if (word_done) begin
        data_q <= word;
        addr_q <= (buf_eff ? BASE1 : '0) + ADDR_W'(idx_eff);
      end
      if (frame_end)      word_idx_q <= '0;
      else if (word_done) word_idx_q <= idx_eff + IDX_W'(1);
      else                word_idx_q <= idx_eff;
      if (frame_end && !bus.start_in) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else if (bus.start_in) begin
        state_q <= ST_RUN;
        busy_q  <= 1'b1;
      end
    end
  end

  assign bus.wr_en_out   = wr_en_q;
  assign bus.addr_w_out  = addr_q;
  assign bus.data_w_out  = data_q;
  assign bus.buf_sel_out = buf_q;
  assign bus.busy_out    = busy_q;
  assign bus.done_out    = done_q;

endmodule

// File: tb/tb_logic_writeback_multi.sv
// Bench for logic_writeback_multi: directed scenarios plus random stimulus against a beat-queue model.
module tb_logic_writeback_multi;

  localparam int NPE = 4;
  localparam int WS  = 16;
  localparam int AW  = 16;
  localparam int WPF = 3;
  localparam int BEATS = WS / NPE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic_writeback_multi_if #(.NUM_PE(NPE), .WORD_SIZE(WS), .ADDR_W(AW)) bus ();

  logic_writeback_multi #(
    .NUM_PE          (NPE),
    .WORD_SIZE       (WS),
    .ADDR_W          (AW),
    .WORDS_PER_FRAME (WPF)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic          mvalid = 1'b0;
  logic          e_wr, e_done, e_buf, e_busy;
  logic [AW-1:0] e_addr;
  logic [WS-1:0] e_data;
  logic [NPE-1:0] beats[$];
  bit  running;
  int  widx;
  int  frame_buf;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      running = 0; beats.delete(); widx = 0; frame_buf = 0;
      e_wr = 0; e_done = 0; e_buf = 0; e_busy = 0; e_addr = '0; e_data = '0;
      mvalid = 1'b1;
    end else begin
      bit acc, fin;
      logic [WS-1:0] w;
      if (e_done) e_buf = frame_buf[0];
      e_wr = 0;
      e_done = 0;
      acc = (running || bus.start_in) && !bus.stall_in;
      fin = running && acc && (beats.size() == BEATS - 1) && (widx == WPF - 1);
      if (bus.start_in && !fin) begin
        beats.delete(); widx = 0; running = 1;
      end
      if (acc) begin
        beats.push_back(bus.next_state_in);
        if (beats.size() == BEATS) begin
          w = '0;
          foreach (beats[k]) w = w | (WS'(beats[k]) << (WS - NPE * (k + 1)));
          e_wr = 1; e_data = w; e_addr = AW'(frame_buf * WPF + widx);
          beats.delete();
          widx++;
          if (widx == WPF) begin
            e_done = 1; widx = 0; frame_buf = 1 - frame_buf; running = bus.start_in;
          end
        end
      end
      e_busy = running;
    end
  end

  // ---------------- compare process + write log ----------------
  typedef struct {
    int            c;
    logic [AW-1:0] addr;
    logic [WS-1:0] data;
    logic          done;
    logic          bsel;
  } wr_t;
  wr_t log_q[$];

  initial forever begin
    @(negedge clk);
    if (mvalid) begin
      chk("wr_en",   32'(bus.wr_en_out),   32'(e_wr));
      chk("addr",    32'(bus.addr_w_out),  32'(e_addr));
      chk("data",    32'(bus.data_w_out),  32'(e_data));
      chk("buf_sel", 32'(bus.buf_sel_out), 32'(e_buf));
      chk("busy",    32'(bus.busy_out),    32'(e_busy));
      chk("done",    32'(bus.done_out),    32'(e_done));
      if (bus.wr_en_out === 1'b1)
        log_q.push_back('{cyc, bus.addr_w_out, bus.data_w_out, bus.done_out, bus.buf_sel_out});
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic s, input logic st, input logic [NPE-1:0] d);
    @(negedge clk);
    bus.start_in = s; bus.stall_in = st; bus.next_state_in = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0);
  endtask

  task automatic rst_pulse();
    @(negedge clk); rst = 1'b1; bus.start_in = 1'b0; bus.stall_in = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  int s;

  initial begin
    bus.start_in = 1'b0; bus.stall_in = 1'b0; bus.next_state_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", 32'(bus.wr_en_out), 0);
    chk("rst_buf",   32'(bus.buf_sel_out), 0);
    chk("rst_busy",  32'(bus.busy_out), 0);
    rst = 1'b0;

    // 1: 12 beats of A; writes 4/8/12 cycles after the start cycle
    log_q.delete();
    drive(1, 0, 4'hA); s = cyc;
    repeat (11) drive(0, 0, 4'hA);
    idle(3);
    chk("s1_count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("s1_data0", log_q[0].data, 16'hAAAA);
      chk("s1_addr0", log_q[0].addr, 0);
      chk("s1_addr2", log_q[2].addr, 2);
      chk("s1_done2", log_q[2].done, 1);
      chk("s1_done0", log_q[0].done, 0);
      chk("s1_lat0",  log_q[0].c - s, 4);
      chk("s1_lat2",  log_q[2].c - s, 12);
    end

    // 2: second frame lands in buffer 1
    log_q.delete();
    for (int i = 0; i < 12; i++) drive(i == 0, 0, 4'(i % 4 + 1));
    idle(3);
    chk("s2_count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("s2_data1", log_q[1].data, 16'h1234);
      chk("s2_addr0", log_q[0].addr, 3);
      chk("s2_addr2", log_q[2].addr, 5);
      chk("s2_buf",   log_q[1].bsel, 1);
    end
    chk("s2_buf_after", 32'(bus.buf_sel_out), 0);

    // 3: stall with garbage between beats 1 and 2
    log_q.delete();
    drive(1, 0, 4'h1); s = cyc;
    drive(0, 1, 4'hF); drive(0, 1, 4'hF);
    drive(0, 0, 4'h2); drive(0, 0, 4'h3); drive(0, 0, 4'h4);
    for (int i = 0; i < 8; i++) drive(0, 0, 4'(i % 4 + 1));
    idle(3);
    chk("s3_count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("s3_data0", log_q[0].data, 16'h1234);
      chk("s3_addr0", log_q[0].addr, 0);
      chk("s3_lat0",  log_q[0].c - s, 6);
    end

    // 4: restart after two beats discards the partial word
    rst_pulse();
    log_q.delete();
    drive(1, 0, 4'h5); drive(0, 0, 4'h6);
    for (int i = 0; i < 12; i++) drive(i == 0, 0, 4'(7 + i % 4));
    idle(3);
    chk("s4_count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("s4_data0", log_q[0].data, 16'h789A);
      chk("s4_addr0", log_q[0].addr, 0);
      chk("s4_addr2", log_q[2].addr, 2);
    end

    // 5: reset mid-word
    log_q.delete();
    drive(1, 0, 4'h3); drive(0, 0, 4'h3);
    @(negedge clk); rst = 1'b1; bus.start_in = 1'b0;
    @(negedge clk); rst = 1'b0;
    chk("s5_wr_en", 32'(bus.wr_en_out), 0);
    chk("s5_addr",  32'(bus.addr_w_out), 0);
    chk("s5_data",  32'(bus.data_w_out), 0);
    chk("s5_busy",  32'(bus.busy_out), 0);
    repeat (6) drive(0, 1'($urandom_range(1)), 4'($urandom));
    idle(2);
    chk("s5_count", log_q.size(), 0);

    // 6: idle beats ignored; stalled start drops its beat
    log_q.delete();
    repeat (5) drive(0, 0, 4'hF);
    idle(2);
    chk("s6_idle_count", log_q.size(), 0);
    drive(1, 1, 4'hF); s = cyc;
    repeat (12) drive(0, 0, 4'hB);
    idle(3);
    chk("s6_count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("s6_lat0",  log_q[0].c - s, 5);
      chk("s6_data0", log_q[0].data, 16'hBBBB);
      chk("s6_addr0", log_q[0].addr, 0);
    end

    // 7: start coincident with the final beat; buffer 1 now, next frame in buffer 0
    log_q.delete();
    for (int i = 0; i < 12; i++) drive(i == 0 || i == 11, 0, 4'hC);
    repeat (12) drive(0, 0, 4'hD);
    idle(3);
    chk("s7_count", log_q.size(), 6);
    if (log_q.size() == 6) begin
      chk("s7_addr2", log_q[2].addr, 5);
      chk("s7_done2", log_q[2].done, 1);
      chk("s7_data2", log_q[2].data, 16'hCCCC);
      chk("s7_addr3", log_q[3].addr, 0);
      chk("s7_data3", log_q[3].data, 16'hDDDD);
      chk("s7_done5", log_q[5].done, 1);
    end

    // random phase, checked cycle by cycle against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(399) == 0);
      bus.start_in = ($urandom_range(29) == 0);
      bus.stall_in = ($urandom_range(3) == 0);
      bus.next_state_in = 4'($urandom);
    end
    @(negedge clk); rst = 1'b0;
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
